// File: rtl/pattern_load_write.sv
// Writer side of the DDR3 pattern store: packs a 32-bit host stream into header + body beats.
// Optional body-word checksum enabled by defining PAT_WR_CHECKSUM_EN.
module pattern_load_write #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned IN_W   = 32
) (
  input  logic                  ddr_emif_clk,
  input  logic                  ddr_emif_rst_n,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  s_valid,
  input  logic                  s_sop,
  input  logic [IN_W-1:0]       s_data,
  output logic                  s_ready,
  input  logic                  ddr_emif_ready,
  output logic                  ddr_emif_write,
  output logic                  ddr_emif_read,
  output logic [ADDR_W-1:0]     ddr_emif_addr,
  output logic [DATA_W-1:0]     ddr_emif_write_data,
  output logic [DATA_W/8-1:0]   ddr_emif_byte_enable,
  output logic [4:0]            ddr_emif_burst_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           pat_checksum
);

  localparam int unsigned WPB = DATA_W / IN_W;
  localparam int unsigned SW  = $clog2(WPB);
  localparam int unsigned BSH = $clog2(DATA_W);
  localparam int unsigned WSH = $clog2(IN_W);
  localparam int unsigned CW  = IN_W + 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(WPB - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, HDR_COL, HDR_WR, BODY_COL, BODY_WR, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   beat;
  logic [ADDR_W-1:0]   addr;
  logic [SW-1:0]       slot;
  logic [CW-1:0]       word_cnt, beat_cnt, n_words, n_beats;
  logic                acc, take_sop;
  logic [DATA_W-1:0]   placed;
  logic [IN_W-1:0]     tot;
  logic [CW-1:0]       need_beats, need_words;

  assign acc      = s_valid & s_ready;
  assign take_sop = acc & s_sop & ((state == IDLE) || (state == HDR_COL) || (state == BODY_COL));
  // Incoming word lands at the MSB end and is shifted down to its slot; beat is pre-cleared.
  assign placed   = {s_data, {(DATA_W-IN_W){1'b0}}} >> (IN_W * int'(slot));
  assign tot        = beat[DATA_W-1-2*IN_W -: IN_W];
  assign need_beats = CW'(tot >> BSH) + CW'(|tot[BSH-1:0]);
  assign need_words = CW'(tot >> WSH) + CW'(|tot[WSH-1:0]);

  assign ddr_emif_read        = 1'b0;
  assign ddr_emif_burst_count = 5'd1;
  assign ddr_emif_addr        = addr;
  assign ddr_emif_write_data  = beat;
  assign ddr_emif_byte_enable = {(DATA_W/8){ddr_emif_write}};

  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) begin
      state          <= IDLE;
      beat           <= '0;
      addr           <= '0;
      slot           <= '0;
      word_cnt       <= '0;
      beat_cnt       <= '0;
      n_words        <= '0;
      n_beats        <= '0;
      s_ready        <= 1'b0;
      ddr_emif_write <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (take_sop) begin
        // A sop mid-pattern aborts and restarts header collection with this word.
        state   <= HDR_COL;
        beat    <= {s_data, {(DATA_W-IN_W){1'b0}}};
        addr    <= base_addr;
        slot    <= SW'(1);
        s_ready <= 1'b1;
        busy    <= 1'b1;
        error   <= (state != IDLE);
      end else begin
        case (state)
          IDLE: s_ready <= 1'b1;
          HDR_COL: if (acc) begin
            beat <= beat | placed;
            slot <= slot + SW'(1);
            if (slot == LAST_SLOT) begin
              state          <= HDR_WR;
              s_ready        <= 1'b0;
              ddr_emif_write <= 1'b1;
              n_beats        <= need_beats;
              n_words        <= need_words;
            end
          end
          HDR_WR: if (ddr_emif_ready) begin
            ddr_emif_write <= 1'b0;
            addr           <= addr + ADDR_W'(1);
            if (n_beats == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= BODY_COL;
              s_ready  <= 1'b1;
              beat     <= '0;
              slot     <= '0;
              word_cnt <= '0;
              beat_cnt <= '0;
            end
          end
          BODY_COL: if (acc) begin
            beat     <= beat | placed;
            slot     <= slot + SW'(1);
            word_cnt <= word_cnt + ONE;
            if ((slot == LAST_SLOT) || (word_cnt + ONE == n_words)) begin
              state          <= BODY_WR;
              s_ready        <= 1'b0;
              ddr_emif_write <= 1'b1;
            end
          end
          BODY_WR: if (ddr_emif_ready) begin
            ddr_emif_write <= 1'b0;
            addr           <= addr + ADDR_W'(1);
            beat_cnt       <= beat_cnt + ONE;
            if (beat_cnt + ONE == n_beats) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= BODY_COL;
              s_ready <= 1'b1;
              beat    <= '0;
              slot    <= '0;
            end
          end
          DONE: begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PAT_WR_CHECKSUM_EN
  logic [31:0] cks;
  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n)
      cks <= '0;
    else if (take_sop)
      cks <= '0;
    else if (acc && (state == BODY_COL))
      cks <= cks + 32'(s_data);
  end
  assign pat_checksum = cks;
`else
  assign pat_checksum = '0;
`endif

endmodule
